// File: rtl/mux_lfmr_sequencer.sv
// Request sequencer for an external pipelined mux: latches one request, waits out the
// mux latency, captures the result and holds it until the downstream handshake.
module mux_lfmr_sequencer #(
    parameter int WIDTH       = 1,
    parameter int INPUT_COUNT = 2,
    parameter int LATENCY     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [$clog2(INPUT_COUNT):0]   s_sel,
    input  logic [WIDTH*INPUT_COUNT-1:0]   s_in,
    output logic [$clog2(INPUT_COUNT):0]   mux_sel,
    output logic [WIDTH*INPUT_COUNT-1:0]   mux_in,
    input  logic [WIDTH-1:0]               mux_out,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [WIDTH-1:0]               m_data,
    output logic                           m_err
);
    localparam int SEL_W = $clog2(INPUT_COUNT) + 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               err_q;
    logic               accept;

    // A finishing result and a new request can share one edge, giving LATENCY+2 throughput.
    assign s_ready = rst_n & ((state == IDLE) | ((state == DONE) & m_ready));
    assign accept  = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_err   <= 1'b0;
            mux_sel <= '0;
            mux_in  <= '0;
        end else begin
            case (state)
                IDLE: ;
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        m_data  <= err_q ? '0 : mux_out;
                        m_err   <= err_q;
                        m_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Accept only happens in IDLE or a completing DONE, so it never races the WAIT branch.
            if (accept) begin
                mux_sel <= s_sel;
                mux_in  <= s_in;
                cnt     <= CNT_W'(LATENCY);
                err_q   <= (s_sel >= SEL_W'(INPUT_COUNT));
                state   <= WAIT;
            end
        end
    end
endmodule

// File: tb/tb_mux_lfmr_sequencer.sv
// Bench for mux_lfmr_sequencer: two configurations (4 words/latency 2, 3 words/latency 0)
// driven by shared directed and random stimulus, checked against a transaction-level model.
module tb_mux_lfmr_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, s_valid, m_ready;
    logic [2:0]  s_sel;
    logic [31:0] s_in;

    logic        a_s_ready, a_m_valid, a_m_err;
    logic [2:0]  a_mux_sel;
    logic [31:0] a_mux_in;
    logic [7:0]  a_mux_out, a_m_data, a_p0, a_p1, a_p2;

    logic        b_s_ready, b_m_valid, b_m_err;
    logic [2:0]  b_mux_sel;
    logic [23:0] b_mux_in;
    logic [7:0]  b_mux_out, b_m_data;

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;
    int rise_q[$];
    bit prev_mv = 1'b0;

    always #5 clk = ~clk;

    mux_lfmr_sequencer #(.WIDTH(8), .INPUT_COUNT(4), .LATENCY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_sel(s_sel), .s_in(s_in), .mux_sel(a_mux_sel), .mux_in(a_mux_in),
        .mux_out(a_mux_out), .m_valid(a_m_valid), .m_ready(m_ready),
        .m_data(a_m_data), .m_err(a_m_err)
    );

    mux_lfmr_sequencer #(.WIDTH(8), .INPUT_COUNT(3), .LATENCY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_sel(s_sel), .s_in(s_in[23:0]), .mux_sel(b_mux_sel), .mux_in(b_mux_in),
        .mux_out(b_mux_out), .m_valid(b_m_valid), .m_ready(m_ready),
        .m_data(b_m_data), .m_err(b_m_err)
    );

    // Attached muxes: a two-stage pipelined one for A, a combinational one for B.
    // Out-of-range selects yield 8'hEE so that result zeroing is observable.
    always_comb a_p0 = (a_mux_sel < 3'd4) ? a_mux_in[a_mux_sel*8 +: 8] : 8'hEE;
    always_ff @(posedge clk) begin
        a_p1 <= a_p0;
        a_p2 <= a_p1;
    end
    assign a_mux_out = a_p2;
    assign b_mux_out = (b_mux_sel < 3'd3) ? b_mux_in[b_mux_sel*8 +: 8] : 8'hEE;

    // Transaction model: a request accepted at edge t yields its result at edge t+L+1.
    typedef struct {
        bit          busy, hold, mv, me, rerr;
        int          due;
        logic [7:0]  res, md;
        logic [2:0]  msel;
        logic [31:0] min;
    } mdl_t;

    mdl_t ma, mb;

    function automatic bit rdy(mdl_t m, bit r, bit mr);
        return r && ((!m.busy && !m.hold) || (m.hold && mr));
    endfunction

    function automatic mdl_t step(mdl_t m, int n, int l, bit r, bit sv, logic [2:0] sel,
                                  logic [31:0] in, bit mr, int tt);
        bit acc;
        if (!r) begin
            m = '{default: 0};
            return m;
        end
        acc = sv && rdy(m, r, mr);
        if (m.hold && mr) begin
            m.hold = 1'b0;
            m.mv   = 1'b0;
        end
        if (m.busy && tt == m.due) begin
            m.busy = 1'b0;
            m.hold = 1'b1;
            m.mv   = 1'b1;
            m.md   = m.res;
            m.me   = m.rerr;
        end
        if (acc) begin
            m.busy = 1'b1;
            m.due  = tt + l + 1;
            m.msel = sel;
            m.min  = in;
            m.rerr = (int'(sel) >= n);
            m.res  = m.rerr ? 8'h00 : in[8*sel +: 8];
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_all();
        chk("a_s_ready", 32'(a_s_ready), 32'(rdy(ma, rst_n, m_ready)));
        chk("a_m_valid", 32'(a_m_valid), 32'(ma.mv));
        chk("a_m_data",  32'(a_m_data),  32'(ma.md));
        chk("a_m_err",   32'(a_m_err),   32'(ma.me));
        chk("a_mux_sel", 32'(a_mux_sel), 32'(ma.msel));
        chk("a_mux_in",  a_mux_in,       ma.min);
        chk("b_s_ready", 32'(b_s_ready), 32'(rdy(mb, rst_n, m_ready)));
        chk("b_m_valid", 32'(b_m_valid), 32'(mb.mv));
        chk("b_m_data",  32'(b_m_data),  32'(mb.md));
        chk("b_m_err",   32'(b_m_err),   32'(mb.me));
        chk("b_mux_sel", 32'(b_mux_sel), 32'(mb.msel));
        chk("b_mux_in",  32'(b_mux_in),  32'(mb.min[23:0]));
    endtask

    // One cycle: drive, check mid-cycle, clock, advance the models.
    task automatic cyc(input bit r, input bit sv, input logic [2:0] sel, input logic [31:0] in,
                       input bit mr);
        rst_n = r; s_valid = sv; s_sel = sel; s_in = in; m_ready = mr;
        #2;
        check_all();
        if (a_m_valid && !prev_mv) rise_q.push_back(t);
        prev_mv = a_m_valid;
        @(posedge clk);
        ma = step(ma, 4, 2, r, sv, sel, in, mr, t);
        mb = step(mb, 3, 0, r, sv, sel, {8'h00, in[23:0]}, mr, t);
        t++;
        #1;
    endtask

    localparam logic [31:0] W = 32'h44332211;

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_sel = '0; s_in = '0; m_ready = 1'b0;
        @(posedge clk);
        #1;
        ma = '{default: 0};
        mb = '{default: 0};

        // Reset held with s_valid high: nothing accepted, s_ready low.
        cyc(1'b0, 1'b1, 3'd2, W, 1'b1);
        cyc(1'b0, 1'b1, 3'd2, W, 1'b1);
        chk("rst_no_accept_a", 32'(a_m_valid), 32'd0);

        // Basic path: result 3 edges after accept on A, 1 edge on B.
        cyc(1'b1, 1'b1, 3'd2, W, 1'b1);
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        chk("lat0_valid_b", 32'(b_m_valid), 32'd1);
        chk("lat0_data_b",  32'(b_m_data),  32'h33);
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b0);
        chk("basic_valid_a", 32'(a_m_valid), 32'd1);
        chk("basic_data_a",  32'(a_m_data),  32'h33);
        chk("basic_err_a",   32'(a_m_err),   32'd0);

        // Backpressure: result holds, changing requests ignored.
        repeat (5) cyc(1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom, 1'b0);
        chk("bp_data_a",  32'(a_m_data),  32'h33);
        chk("bp_ready_a", 32'(a_s_ready), 32'd0);
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 1'b1);

        // Back-to-back: sel 1 then 3 with s_valid held.
        rise_q.delete();
        cyc(1'b1, 1'b1, 3'd1, W, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, 3'd3, W, 1'b1);
        chk("b2b_first", 32'(a_m_data), 32'h22);
        cyc(1'b1, 1'b1, 3'd3, W, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 3'd0, W, 1'b1);
        chk("b2b_second", 32'(a_m_data), 32'h44);
        cyc(1'b1, 1'b0, 3'd0, W, 1'b1);
        chk("b2b_pulses", 32'(rise_q.size()), 32'd2);
        if (rise_q.size() == 2) chk("b2b_spacing", 32'(rise_q[1] - rise_q[0]), 32'd4);
        repeat (2) cyc(1'b1, 1'b0, 3'd0, W, 1'b1);

        // Out-of-range select on the 3-word configuration.
        cyc(1'b1, 1'b1, 3'd3, W, 1'b1);
        cyc(1'b1, 1'b0, 3'd0, W, 1'b0);
        chk("oor_valid_b", 32'(b_m_valid), 32'd1);
        chk("oor_err_b",   32'(b_m_err),   32'd1);
        chk("oor_data_b",  32'(b_m_data),  32'd0);
        repeat (4) cyc(1'b1, 1'b0, 3'd0, W, 1'b1);

        // Reset mid-WAIT abandons the request.
        rise_q.delete();
        cyc(1'b1, 1'b1, 3'd0, W, 1'b1);
        cyc(1'b1, 1'b0, 3'd0, W, 1'b1);
        cyc(1'b0, 1'b0, 3'd0, W, 1'b1);
        chk("rst_mid_valid_a", 32'(a_m_valid), 32'd0);
        repeat (5) cyc(1'b1, 1'b0, 3'd0, W, 1'b1);
        chk("rst_mid_no_result", 32'(rise_q.size()), 32'd0);

        // Random traffic with occasional resets and backpressure.
        repeat (400)
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
                3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
